riscv_dbiu_ahb: RTL and testbench
=================================

# riscv_dbiu_ahb

Data-side bus interface unit that converts the single-transfer BIU request/acknowledge protocol into AHB-Lite master transactions. It sits directly downstream of the no-data-cache memory core. It accepts that core's `biu_*` strobe, address, size, lock, prot and write-data signals, and returns the stb/data/ack/err acknowledges and read data that the core's in-flight and discard counters rely on. It pipelines the AHB address phase of one transfer with the data phase of the previous one, so at most two transfers are outstanding.

## Interface
- XLEN, 32: data width (32 or 64).
- PLEN, XLEN: physical address width.
- clk_i  in  1  clock. Reset `rst_ni`, asynchronous, active-low; clock `clk_i`.
- rst_ni  in  1  asynchronous active-low reset.
- biu_stb_i  in  1  transfer request.
- biu_stb_ack_o  out  1  request accepted (address phase issued next edge).
- biu_d_ack_o  out  1  write data captured.
- biu_adri_i  in  PLEN  request address.
- biu_adro_o  out  PLEN  address currently in AHB address phase.
- biu_size_i  in  biu_size_t  BYTE/HWORD/WORD/DWORD.
- biu_type_i  in  biu_type_t  burst type; only SINGLE supported.
- biu_lock_i  in  1  locked transfer.
- biu_prot_i  in  biu_prot_t  protection attributes.
- biu_we_i  in  1  write enable.
- biu_d_i  in  XLEN  write data.
- biu_q_o  out  XLEN  read data.
- biu_ack_o  out  1  transfer completed OK.
- biu_err_o  out  1  transfer completed with error.
- HSEL  out  1. HADDR  out  PLEN. HWDATA  out  XLEN. HRDATA  in  XLEN. HWRITE  out  1. HSIZE  out  3. HBURST  out  3. HPROT  out  4. HTRANS  out  2. HMASTLOCK  out  1. HREADY  in  1. HRESP  in  1.

## Operation
- Address-phase registers: HSEL, HADDR, HWRITE, HSIZE, HPROT, HTRANS, HMASTLOCK, and the held write data `wd_q`.
- Data-phase state: DP_IDLE, DP_ACTIVE, DP_CANCEL. DP_ACTIVE records `dp_we`.
- `biu_stb_ack_o = rst_ni & biu_stb_i & HREADY & (state != DP_CANCEL) & ~(HRESP & dp_active)`.
- On a clock edge with HREADY=1, these updates happen together:
  - Address phase moves to data phase: the state becomes DP_ACTIVE if HTRANS==NONSEQ, else DP_IDLE. `HWDATA <= wd_q`.
  - If `biu_stb_ack_o`: HTRANS←NONSEQ (2), HSEL←1, HADDR←biu_adri_i, HWRITE←biu_we_i, HSIZE←{1'b0,size} (BYTE=0, HWORD=1, WORD=2, DWORD=3), HMASTLOCK←biu_lock_i, wd_q←biu_d_i.
  - Otherwise: HTRANS←IDLE (0), HSEL←0. HMASTLOCK holds its value while biu_lock_i=1, else becomes 0.
- `biu_d_ack_o = biu_stb_ack_o & biu_we_i`.
- HBURST is always SINGLE (0); biu_type_i is ignored.
- HPROT: [0]=PROT_DATA, [1]=PROT_PRIVILEGED, [3:2]=0.
- `biu_ack_o = dp_active & HREADY & ~HRESP`. `biu_q_o = HRDATA`, valid when biu_ack_o=1 and dp_we=0.
- Error handling (two-cycle AHB ERROR response):
  - Cycle 1 (dp_active, HRESP=1, HREADY=0): address-phase registers take HTRANS←IDLE, HSEL←0. A pending NONSEQ address phase is cancelled and the state goes to DP_CANCEL if one was pending.
  - Cycle 2 (HRESP=1, HREADY=1): `biu_err_o=1`.
  - When the state is DP_CANCEL, the cycle after cycle 2 pulses `biu_err_o=1` for the cancelled transfer, then the state goes to DP_IDLE. No stb_ack is given during DP_CANCEL.
  - Every accepted request therefore receives exactly one biu_ack_o or biu_err_o.
- `biu_adro_o = HADDR`.

## Timing
- Reset values: HTRANS=0, HSEL=0, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=0, HMASTLOCK=0, HWDATA=0, wd_q=0, state=DP_IDLE.
- While in reset, biu_stb_ack_o, biu_d_ack_o, biu_ack_o and biu_err_o are 0.
- Zero wait states: stb_ack at cycle N, address phase at N+1, biu_ack_o at N+2. Back-to-back requests sustain one transfer per cycle.
- HREADY=0: all address-phase registers hold, stb_ack is 0, and no ack is given.
- If HRESP=1 with HREADY=1 arrives without a preceding HREADY=0 cycle (protocol violation), it is still reported as biu_err_o. No cancel takes place.
- Reset asserted mid-transfer: all state is cleared immediately. The outstanding transfer is dropped and no ack or err is produced.

## Test plan
- Single WORD read of 0x100, HRDATA=0xDEADBEEF, zero waits: stb_ack at c0, HTRANS=2 and HADDR=0x100 at c1, biu_ack_o=1 and biu_q_o=0xDEADBEEF at c2.
- Four back-to-back writes to 0x0/0x4/0x8/0xC with data 1..4: one stb_ack and one d_ack per cycle. HWDATA carries 1..4 one cycle after the matching HADDR. Four biu_ack_o pulses.
- Read with 2 HREADY=0 wait cycles while a second request is pending: HADDR holds the second address, stb_ack is 0 during the waits, and the ack arrives after the waits end.
- Error on the first of two pipelined reads: HTRANS goes to 0 in the cycle after HRESP&~HREADY. biu_err_o pulses twice in consecutive cycles and biu_ack_o is never asserted.
- Locked BYTE write at 0x3 with biu_lock_i held for 2 transfers: HMASTLOCK=1 across both address phases, HSIZE=0, HPROT[0]=1. HMASTLOCK drops after lock is released with no request.
- Assert rst_ni=0 during a data phase: all AHB outputs are 0 asynchronously. After release, a new read completes normally with exactly one ack.

Source files
------------

// File: rtl/riscv_dbiu_ahb_if.sv
// -----------------------------------------------------------------------------
// riscv_dbiu_ahb_if
// Bundles the two buses seen by the data-side BIU:
//   - BIU side  (biu_*): single-transfer request/acknowledge from the memory core
//   - AHB side  (H*)   : AHB-Lite master signals
// Modports:
//   master : the bus interface unit (drives AHB address/control, BIU acks)
//   slave  : the environment (memory core + AHB slave/interconnect)
// Parameters:
//   XLEN : data width (32 or 64)
//   PLEN : physical address width
// -----------------------------------------------------------------------------
interface riscv_dbiu_ahb_if #(
  parameter int XLEN = 32,
  parameter int PLEN = XLEN
);
  // BIU side
  logic            biu_stb_i;
  logic            biu_stb_ack_o;
  logic            biu_d_ack_o;
  logic [PLEN-1:0] biu_adri_i;
  logic [PLEN-1:0] biu_adro_o;
  logic [1:0]      biu_size_i;   // 0=BYTE 1=HWORD 2=WORD 3=DWORD
  logic [2:0]      biu_type_i;   // burst type, only SINGLE is used
  logic            biu_lock_i;
  logic [2:0]      biu_prot_i;   // [0]=data access, [1]=privileged, [2]=cacheable
  logic            biu_we_i;
  logic [XLEN-1:0] biu_d_i;
  logic [XLEN-1:0] biu_q_o;
  logic            biu_ack_o;
  logic            biu_err_o;

  // AHB-Lite side
  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic [XLEN-1:0] HRDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic            HREADY;
  logic            HRESP;

  modport master (
    input  biu_stb_i, biu_adri_i, biu_size_i, biu_type_i, biu_lock_i,
           biu_prot_i, biu_we_i, biu_d_i,
    output biu_stb_ack_o, biu_d_ack_o, biu_adro_o, biu_q_o, biu_ack_o, biu_err_o,
    output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output biu_stb_i, biu_adri_i, biu_size_i, biu_type_i, biu_lock_i,
           biu_prot_i, biu_we_i, biu_d_i,
    input  biu_stb_ack_o, biu_d_ack_o, biu_adro_o, biu_q_o, biu_ack_o, biu_err_o,
    input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/riscv_dbiu_ahb.sv
// -----------------------------------------------------------------------------
// riscv_dbiu_ahb
// Data-side bus interface unit: converts single-transfer BIU requests into
// AHB-Lite master transfers. The address phase of one transfer overlaps the
// data phase of the previous one, so at most two transfers are outstanding.
// Every accepted request gets exactly one biu_ack_o or biu_err_o.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : riscv_dbiu_ahb_if.master (BIU request/ack side + AHB-Lite master)
// -----------------------------------------------------------------------------
module riscv_dbiu_ahb #(
  parameter int XLEN = 32,
  parameter int PLEN = XLEN
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  riscv_dbiu_ahb_if.master      bus
);

  localparam logic [1:0] DP_IDLE   = 2'd0;
  localparam logic [1:0] DP_ACTIVE = 2'd1;
  localparam logic [1:0] DP_CANCEL = 2'd2;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;

  // Address-phase registers
  logic            hsel_q,      hsel_d;
  logic [PLEN-1:0] haddr_q,     haddr_d;
  logic            hwrite_q,    hwrite_d;
  logic [2:0]      hsize_q,     hsize_d;
  logic [3:0]      hprot_q,     hprot_d;
  logic [1:0]      htrans_q,    htrans_d;
  logic            hmastlock_q, hmastlock_d;
  logic [XLEN-1:0] wd_q,        wd_d;
  logic [XLEN-1:0] hwdata_q,    hwdata_d;

  // Data-phase state
  logic [1:0]      state_q,     state_d;
  logic            dp_we_q,     dp_we_d;
  // Set during the first (HREADY=0) cycle of an ERROR response when a NONSEQ
  // address phase is pending behind the failing transfer.
  logic            cancel_q,    cancel_d;

  logic            dp_active;
  logic            stb_ack;

  assign dp_active = (state_q == DP_ACTIVE);

  // No new request while an error is being retired or a cancelled transfer
  // still owes its error pulse.
  assign stb_ack = rst_ni & bus.biu_stb_i & bus.HREADY & (state_q != DP_CANCEL)
                 & ~(bus.HRESP & dp_active);

  always_comb begin
    hsel_d      = hsel_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hprot_d     = hprot_q;
    htrans_d    = htrans_q;
    hmastlock_d = hmastlock_q;
    wd_d        = wd_q;
    hwdata_d    = hwdata_q;
    state_d     = state_q;
    dp_we_d     = dp_we_q;
    cancel_d    = cancel_q;

    // Address phase
    if (bus.HREADY) begin
      hwdata_d = wd_q;
      if (stb_ack) begin
        htrans_d    = HTRANS_NONSEQ;
        hsel_d      = 1'b1;
        haddr_d     = bus.biu_adri_i;
        hwrite_d    = bus.biu_we_i;
        hsize_d     = {1'b0, bus.biu_size_i};
        hprot_d     = {2'b00, bus.biu_prot_i[1:0]};
        hmastlock_d = bus.biu_lock_i;
        wd_d        = bus.biu_d_i;
      end else begin
        htrans_d    = HTRANS_IDLE;
        hsel_d      = 1'b0;
        hmastlock_d = hmastlock_q & bus.biu_lock_i;
      end
    end else if (dp_active && bus.HRESP) begin
      // First ERROR cycle: withdraw any pending address phase.
      htrans_d = HTRANS_IDLE;
      hsel_d   = 1'b0;
    end

    // Data phase
    if (state_q == DP_CANCEL) begin
      state_d  = DP_IDLE;
      cancel_d = 1'b0;
    end else if (bus.HREADY) begin
      cancel_d = 1'b0;
      if (cancel_q) begin
        state_d = DP_CANCEL;
      end else if (htrans_q == HTRANS_NONSEQ) begin
        state_d = DP_ACTIVE;
        dp_we_d = hwrite_q;
      end else begin
        state_d = DP_IDLE;
      end
    end else if (dp_active && bus.HRESP && (htrans_q == HTRANS_NONSEQ)) begin
      cancel_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hsel_q      <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      hprot_q     <= 4'b0000;
      htrans_q    <= HTRANS_IDLE;
      hmastlock_q <= 1'b0;
      wd_q        <= '0;
      hwdata_q    <= '0;
      state_q     <= DP_IDLE;
      dp_we_q     <= 1'b0;
      cancel_q    <= 1'b0;
    end else begin
      hsel_q      <= hsel_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hprot_q     <= hprot_d;
      htrans_q    <= htrans_d;
      hmastlock_q <= hmastlock_d;
      wd_q        <= wd_d;
      hwdata_q    <= hwdata_d;
      state_q     <= state_d;
      dp_we_q     <= dp_we_d;
      cancel_q    <= cancel_d;
    end
  end

  // AHB outputs
  assign bus.HSEL      = hsel_q;
  assign bus.HADDR     = haddr_q;
  assign bus.HWDATA    = hwdata_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HSIZE     = hsize_q;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = hprot_q;
  assign bus.HTRANS    = htrans_q;
  assign bus.HMASTLOCK = hmastlock_q;

  // BIU outputs
  assign bus.biu_stb_ack_o = stb_ack;
  assign bus.biu_d_ack_o   = stb_ack & bus.biu_we_i;
  assign bus.biu_adro_o    = haddr_q;
  assign bus.biu_q_o       = bus.HRDATA;
  assign bus.biu_ack_o     = dp_active & bus.HREADY & ~bus.HRESP;
  // Second ERROR cycle reports the failing transfer; the DP_CANCEL cycle
  // reports the transfer whose address phase was withdrawn.
  assign bus.biu_err_o     = (dp_active & bus.HREADY & bus.HRESP) | (state_q == DP_CANCEL);

  // Burst type is always SINGLE; the cacheable prot bit has no AHB-Lite
  // counterpart here; dp_we only qualifies biu_q_o for the consumer.
  logic unused_inputs;
  assign unused_inputs = ^{bus.biu_type_i, bus.biu_prot_i[2], dp_we_q};

endmodule

// File: tb/tb_riscv_dbiu_ahb.sv
module tb_riscv_dbiu_ahb;
  localparam int XLEN = 32;
  localparam int PLEN = 32;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;

  riscv_dbiu_ahb_if #(.XLEN(XLEN), .PLEN(PLEN)) bus ();

  riscv_dbiu_ahb #(.XLEN(XLEN), .PLEN(PLEN)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    bus.biu_stb_i  = 1'b0;
    bus.biu_adri_i = '0;
    bus.biu_size_i = 2'd2;
    bus.biu_type_i = 3'd0;
    bus.biu_lock_i = 1'b0;
    bus.biu_prot_i = 3'b011;
    bus.biu_we_i   = 1'b0;
    bus.biu_d_i    = '0;
    bus.HRDATA     = '0;
    bus.HREADY     = 1'b1;
    bus.HRESP      = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_ni = 1'b0;
    bus.biu_stb_i = 1'b1;
    bus.biu_we_i  = 1'b1;
    #12;
    checks++; if (bus.biu_stb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_stb_ack got %0b exp 0", bus.biu_stb_ack_o); end
    checks++; if (bus.biu_d_ack_o !== 1'b0) begin errors++; $display("FAIL reset_d_ack got %0b exp 0", bus.biu_d_ack_o); end
    checks++; if ({bus.biu_ack_o, bus.biu_err_o} !== 2'b00) begin errors++; $display("FAIL reset_ack_err got %b exp 00", {bus.biu_ack_o, bus.biu_err_o}); end
    checks++; if ({bus.HTRANS, bus.HSEL, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK} !== 15'd0) begin
      errors++; $display("FAIL reset_ctrl got %h exp 0", {bus.HTRANS, bus.HSEL, bus.HWRITE, bus.HSIZE, bus.HBURST, bus.HPROT, bus.HMASTLOCK});
    end
    checks++; if ({bus.HADDR, bus.HWDATA} !== 64'd0) begin errors++; $display("FAIL reset_addr_data got %h exp 0", {bus.HADDR, bus.HWDATA}); end
    drive_idle();
    #10 rst_ni = 1'b1;
  endtask

  task automatic test_single_read();
    tick();
    bus.biu_stb_i = 1'b1; bus.biu_adri_i = 32'h100; bus.biu_we_i = 1'b0; bus.biu_size_i = 2'd2;
    #1;
    checks++; if ({bus.biu_stb_ack_o, bus.biu_d_ack_o} !== 2'b10) begin errors++; $display("FAIL rd_stb_ack got %b exp 10", {bus.biu_stb_ack_o, bus.biu_d_ack_o}); end
    tick();
    bus.biu_stb_i = 1'b0;
    #1;
    checks++; if ({bus.HTRANS, bus.HSEL, bus.HWRITE, bus.HSIZE} !== 7'b10_1_0_010) begin
      errors++; $display("FAIL rd_addr_phase_ctrl got %b exp 1010010", {bus.HTRANS, bus.HSEL, bus.HWRITE, bus.HSIZE});
    end
    checks++; if (bus.HADDR !== 32'h100 || bus.biu_adro_o !== 32'h100) begin errors++; $display("FAIL rd_haddr got %h/%h exp 100", bus.HADDR, bus.biu_adro_o); end
    checks++; if (bus.HPROT !== 4'b0011) begin errors++; $display("FAIL rd_hprot got %b exp 0011", bus.HPROT); end
    checks++; if (bus.biu_ack_o !== 1'b0) begin errors++; $display("FAIL rd_early_ack got %0b exp 0", bus.biu_ack_o); end
    tick();
    bus.HRDATA = 32'hDEADBEEF;
    #1;
    checks++; if (bus.biu_ack_o !== 1'b1) begin errors++; $display("FAIL rd_ack got %0b exp 1", bus.biu_ack_o); end
    checks++; if (bus.biu_q_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_q got %h exp deadbeef", bus.biu_q_o); end
    checks++; if (bus.HTRANS !== 2'd0) begin errors++; $display("FAIL rd_htrans_idle got %0d exp 0", bus.HTRANS); end
    tick();
    #1;
    checks++; if (bus.biu_ack_o !== 1'b0) begin errors++; $display("FAIL rd_ack_once got %0b exp 0", bus.biu_ack_o); end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      bus.biu_stb_i  = (i < 4);
      bus.biu_we_i   = 1'b1;
      bus.biu_adri_i = 32'(4 * i);
      bus.biu_d_i    = 32'(i + 1);
      #1;
      if (i < 4) begin
        checks++; if ({bus.biu_stb_ack_o, bus.biu_d_ack_o} !== 2'b11) begin errors++; $display("FAIL b2b_stb_d_ack[%0d] got %b exp 11", i, {bus.biu_stb_ack_o, bus.biu_d_ack_o}); end
      end
      if (i >= 1 && i <= 4) begin
        checks++; if (bus.HADDR !== 32'(4 * (i - 1)) || bus.HTRANS !== 2'd2 || bus.HWRITE !== 1'b1) begin
          errors++; $display("FAIL b2b_addr[%0d] got %h/%0d/%0b exp %h/2/1", i, bus.HADDR, bus.HTRANS, bus.HWRITE, 32'(4 * (i - 1)));
        end
      end
      if (i >= 2 && i <= 5) begin
        checks++; if (bus.HWDATA !== 32'(i - 1)) begin errors++; $display("FAIL b2b_hwdata[%0d] got %h exp %h", i, bus.HWDATA, 32'(i - 1)); end
      end
      if (bus.biu_ack_o === 1'b1) acks++;
    end
    checks++; if (acks !== 4) begin errors++; $display("FAIL b2b_ack_count got %0d exp 4", acks); end
    drive_idle();
  endtask

  task automatic test_wait_states();
    tick();
    bus.biu_stb_i = 1'b1; bus.biu_adri_i = 32'h200;
    #1;
    checks++; if (bus.biu_stb_ack_o !== 1'b1) begin errors++; $display("FAIL ws_stb_ack_a got %0b exp 1", bus.biu_stb_ack_o); end
    tick();
    bus.biu_adri_i = 32'h204;
    #1;
    checks++; if (bus.biu_stb_ack_o !== 1'b1 || bus.HADDR !== 32'h200) begin errors++; $display("FAIL ws_stb_ack_b got %0b/%h exp 1/200", bus.biu_stb_ack_o, bus.HADDR); end
    for (int w = 0; w < 2; w++) begin
      tick();
      bus.biu_adri_i = 32'h208; bus.HREADY = 1'b0;
      #1;
      checks++; if ({bus.biu_stb_ack_o, bus.biu_ack_o} !== 2'b00) begin errors++; $display("FAIL ws_wait_acks[%0d] got %b exp 00", w, {bus.biu_stb_ack_o, bus.biu_ack_o}); end
      checks++; if (bus.HADDR !== 32'h204 || bus.HTRANS !== 2'd2) begin errors++; $display("FAIL ws_hold_addr[%0d] got %h/%0d exp 204/2", w, bus.HADDR, bus.HTRANS); end
    end
    tick();
    bus.HREADY = 1'b1; bus.HRDATA = 32'h11111111;
    #1;
    checks++; if ({bus.biu_ack_o, bus.biu_stb_ack_o} !== 2'b11 || bus.biu_q_o !== 32'h11111111) begin
      errors++; $display("FAIL ws_ack_a got %b/%h exp 11/11111111", {bus.biu_ack_o, bus.biu_stb_ack_o}, bus.biu_q_o);
    end
    tick();
    bus.biu_stb_i = 1'b0; bus.HRDATA = 32'h22222222;
    #1;
    checks++; if (bus.biu_ack_o !== 1'b1 || bus.HADDR !== 32'h208) begin errors++; $display("FAIL ws_ack_b got %0b/%h exp 1/208", bus.biu_ack_o, bus.HADDR); end
    tick();
    #1;
    checks++; if (bus.biu_ack_o !== 1'b1) begin errors++; $display("FAIL ws_ack_c got %0b exp 1", bus.biu_ack_o); end
    tick();
    #1;
    checks++; if (bus.biu_ack_o !== 1'b0) begin errors++; $display("FAIL ws_ack_end got %0b exp 0", bus.biu_ack_o); end
    drive_idle();
  endtask

  task automatic test_error();
    tick();
    bus.biu_stb_i = 1'b1; bus.biu_adri_i = 32'h300;
    #1;
    checks++; if (bus.biu_stb_ack_o !== 1'b1) begin errors++; $display("FAIL err_stb_ack_a got %0b exp 1", bus.biu_stb_ack_o); end
    tick();
    bus.biu_adri_i = 32'h304;
    #1;
    checks++; if (bus.biu_stb_ack_o !== 1'b1) begin errors++; $display("FAIL err_stb_ack_b got %0b exp 1", bus.biu_stb_ack_o); end
    tick();
    bus.biu_stb_i = 1'b0; bus.HRESP = 1'b1; bus.HREADY = 1'b0;
    #1;
    checks++; if ({bus.biu_ack_o, bus.biu_err_o} !== 2'b00 || bus.HTRANS !== 2'd2) begin
      errors++; $display("FAIL err_cycle1 got %b/%0d exp 00/2", {bus.biu_ack_o, bus.biu_err_o}, bus.HTRANS);
    end
    tick();
    bus.HREADY = 1'b1;
    #1;
    checks++; if (bus.HTRANS !== 2'd0 || bus.HSEL !== 1'b0) begin errors++; $display("FAIL err_htrans_cancel got %0d/%0b exp 0/0", bus.HTRANS, bus.HSEL); end
    checks++; if ({bus.biu_ack_o, bus.biu_err_o} !== 2'b01) begin errors++; $display("FAIL err_first_pulse got %b exp 01", {bus.biu_ack_o, bus.biu_err_o}); end
    tick();
    bus.HRESP = 1'b0; bus.biu_stb_i = 1'b1; bus.biu_adri_i = 32'h308;
    #1;
    checks++; if ({bus.biu_ack_o, bus.biu_err_o, bus.biu_stb_ack_o} !== 3'b010) begin
      errors++; $display("FAIL err_cancel_pulse got %b exp 010", {bus.biu_ack_o, bus.biu_err_o, bus.biu_stb_ack_o});
    end
    tick();
    #1;
    checks++; if ({bus.biu_ack_o, bus.biu_err_o, bus.biu_stb_ack_o} !== 3'b001) begin
      errors++; $display("FAIL err_recover got %b exp 001", {bus.biu_ack_o, bus.biu_err_o, bus.biu_stb_ack_o});
    end
    tick();
    bus.biu_stb_i = 1'b0;
    #1;
    checks++; if (bus.HADDR !== 32'h308 || bus.HTRANS !== 2'd2) begin errors++; $display("FAIL err_next_addr got %h/%0d exp 308/2", bus.HADDR, bus.HTRANS); end
    tick();
    #1;
    checks++; if ({bus.biu_ack_o, bus.biu_err_o} !== 2'b10) begin errors++; $display("FAIL err_next_ack got %b exp 10", {bus.biu_ack_o, bus.biu_err_o}); end
    drive_idle();
  endtask

  task automatic test_lock();
    tick();
    bus.biu_stb_i = 1'b1; bus.biu_adri_i = 32'h3; bus.biu_we_i = 1'b1; bus.biu_size_i = 2'd0;
    bus.biu_lock_i = 1'b1; bus.biu_prot_i = 3'b001; bus.biu_d_i = 32'hA5;
    #1;
    checks++; if ({bus.biu_stb_ack_o, bus.biu_d_ack_o} !== 2'b11) begin errors++; $display("FAIL lk_acks got %b exp 11", {bus.biu_stb_ack_o, bus.biu_d_ack_o}); end
    tick();
    bus.biu_adri_i = 32'h4; bus.biu_d_i = 32'h5A;
    #1;
    checks++; if ({bus.HMASTLOCK, bus.HSIZE, bus.HPROT, bus.HBURST} !== 11'b1_000_0001_000 || bus.HADDR !== 32'h3) begin
      errors++; $display("FAIL lk_first got %b/%h exp 10000001000/3", {bus.HMASTLOCK, bus.HSIZE, bus.HPROT, bus.HBURST}, bus.HADDR);
    end
    tick();
    bus.biu_stb_i = 1'b0;
    #1;
    checks++; if (bus.HMASTLOCK !== 1'b1 || bus.HADDR !== 32'h4 || bus.HTRANS !== 2'd2) begin
      errors++; $display("FAIL lk_second got %0b/%h/%0d exp 1/4/2", bus.HMASTLOCK, bus.HADDR, bus.HTRANS);
    end
    tick();
    bus.biu_lock_i = 1'b0;
    #1;
    checks++; if (bus.HMASTLOCK !== 1'b1 || bus.HTRANS !== 2'd0) begin errors++; $display("FAIL lk_hold got %0b/%0d exp 1/0", bus.HMASTLOCK, bus.HTRANS); end
    tick();
    #1;
    checks++; if (bus.HMASTLOCK !== 1'b0) begin errors++; $display("FAIL lk_release got %0b exp 0", bus.HMASTLOCK); end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    int acks;
    acks = 0;
    tick();
    bus.biu_stb_i = 1'b1; bus.biu_adri_i = 32'h400;
    #1;
    tick();
    bus.biu_stb_i = 1'b0;
    #1;
    tick();
    bus.HREADY = 1'b0;
    #1;
    checks++; if (bus.HADDR !== 32'h400 || bus.biu_ack_o !== 1'b0) begin errors++; $display("FAIL rm_pre got %h/%0b exp 400/0", bus.HADDR, bus.biu_ack_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if ({bus.HTRANS, bus.HSEL, bus.HADDR, bus.HMASTLOCK, bus.HWRITE} !== 37'd0) begin
      errors++; $display("FAIL rm_async_clear got %h exp 0", {bus.HTRANS, bus.HSEL, bus.HADDR, bus.HMASTLOCK, bus.HWRITE});
    end
    checks++; if ({bus.biu_ack_o, bus.biu_err_o} !== 2'b00) begin errors++; $display("FAIL rm_acks got %b exp 00", {bus.biu_ack_o, bus.biu_err_o}); end
    #2;
    bus.HREADY = 1'b1;
    rst_ni = 1'b1;
    tick();
    #1;
    if (bus.biu_ack_o === 1'b1 || bus.biu_err_o === 1'b1) acks++;
    tick();
    bus.biu_stb_i = 1'b1; bus.biu_adri_i = 32'h500; bus.HRDATA = 32'hCAFEF00D;
    #1;
    checks++; if (bus.biu_stb_ack_o !== 1'b1) begin errors++; $display("FAIL rm_new_stb_ack got %0b exp 1", bus.biu_stb_ack_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.biu_stb_i = 1'b0;
      #1;
      if (bus.biu_ack_o === 1'b1 || bus.biu_err_o === 1'b1) begin
        acks++;
        checks++; if (bus.biu_q_o !== 32'hCAFEF00D || bus.biu_err_o !== 1'b0) begin errors++; $display("FAIL rm_new_q got %h/%0b exp cafef00d/0", bus.biu_q_o, bus.biu_err_o); end
      end
    end
    checks++; if (acks !== 1) begin errors++; $display("FAIL rm_ack_count got %0d exp 1", acks); end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_lock();
    test_reset_mid();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout reached exp finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
